// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with format auto-decode and a 2-entry output buffer.
// Latency 1 cycle; in_ready is registered (count < 2) and never depends combinationally on out_ready.
module imm_gen_pipe #(
   parameter int XLEN        = 32,
   parameter bit AUTO_DECODE = 1'b1,
   parameter int TAG_W       = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_immsrc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_immext,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [2:0] FMT_SHAMT = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_S     = 3'd2;
   localparam logic [2:0] FMT_B     = 3'd3;
   localparam logic [2:0] FMT_U     = 3'd4;
   localparam logic [2:0] FMT_J     = 3'd5;
   localparam logic [2:0] FMT_ZIMM  = 3'd6;
   localparam logic [2:0] FMT_RSVD  = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [2:0]       fmt;
      logic             ill;
      logic [TAG_W-1:0] tag;
   } entry_t;

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [2:0]      w_fmt;
   logic            w_zero_imm;
   logic            w_shamt5;
   logic            w_sext;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_ext;
   entry_t          w_new;

   assign w_opcode = in_instr[6:0];
   assign w_funct3 = in_instr[14:12];

   // funct3 001/101 are the shift-immediate forms.
   always_comb begin
      w_fmt      = FMT_RSVD;
      w_zero_imm = 1'b0;
      w_shamt5   = 1'b0;
      if (AUTO_DECODE) begin
         case (w_opcode)
            7'b0010011: w_fmt = (w_funct3[1:0] == 2'b01) ? FMT_SHAMT : FMT_I;
            7'b0011011: begin
               if (XLEN == 64) begin
                  w_fmt    = (w_funct3[1:0] == 2'b01) ? FMT_SHAMT : FMT_I;
                  w_shamt5 = 1'b1;
               end
            end
            7'b0000011, 7'b1100111: w_fmt = FMT_I;
            7'b0100011: w_fmt = FMT_S;
            7'b1100011: w_fmt = FMT_B;
            7'b0110111, 7'b0010111: w_fmt = FMT_U;
            7'b1101111: w_fmt = FMT_J;
            7'b1110011: w_fmt = w_funct3[2] ? FMT_ZIMM : FMT_I;
            7'b0110011: begin
               w_fmt      = FMT_SHAMT;
               w_zero_imm = 1'b1;
            end
            default: w_fmt = FMT_RSVD;
         endcase
      end else begin
         w_fmt = in_immsrc;
      end
   end

   always_comb begin
      w_imm32 = 32'd0;
      w_sext  = 1'b1;
      case (w_fmt)
         FMT_SHAMT: begin
            w_imm32 = {26'd0, (XLEN == 64) && !w_shamt5 && in_instr[25], in_instr[24:20]};
            w_sext  = 1'b0;
         end
         FMT_I:    w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S:    w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B:    w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U:    w_imm32 = {in_instr[31:12], 12'd0};
         FMT_J:    w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
         FMT_ZIMM: begin
            w_imm32 = {27'd0, in_instr[19:15]};
            w_sext  = 1'b0;
         end
         default:  w_imm32 = 32'd0;
      endcase
   end

   assign w_ext = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);

   always_comb begin
      w_new.imm = w_zero_imm ? '0 : w_ext;
      w_new.fmt = w_fmt;
      w_new.ill = (w_fmt == FMT_RSVD);
      w_new.tag = in_tag;
   end

   entry_t     r_ent0;
   entry_t     r_ent1;
   logic [1:0] r_count;
   logic       r_in_ready;
   logic       w_push;
   logic       w_pop;
   logic [1:0] w_cnt_after_pop;
   logic [1:0] w_cnt_next;

   assign in_ready        = r_in_ready;
   assign out_valid       = (r_count != 2'd0);
   assign w_push          = in_valid & r_in_ready;
   assign w_pop           = out_valid & out_ready;
   assign w_cnt_after_pop = r_count - {1'b0, w_pop};
   assign w_cnt_next      = w_cnt_after_pop + {1'b0, w_push};

   // r_ent0 is always the head; a push lands in the first free slot after the pop shift.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ent0     <= '0;
         r_ent1     <= '0;
         r_count    <= 2'd0;
         r_in_ready <= 1'b0;
      end else if (flush) begin
         r_ent0     <= '0;
         r_ent1     <= '0;
         r_count    <= 2'd0;
         r_in_ready <= 1'b1;
      end else begin
         if (w_pop) begin
            r_ent0 <= r_ent1;
         end
         if (w_push) begin
            if (w_cnt_after_pop == 2'd0) begin
               r_ent0 <= w_new;
            end else begin
               r_ent1 <= w_new;
            end
         end
         r_count    <= w_cnt_next;
         r_in_ready <= (w_cnt_next != 2'd2);
      end
   end

   assign out_immext  = r_ent0.imm;
   assign out_fmt     = r_ent0.fmt;
   assign out_illegal = r_ent0.ill;
   assign out_tag     = r_ent0.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (RV32 auto, RV64 auto, RV32 external format) share one stimulus stream.
// Directed encodings, backpressure, flush and reset cases, then randomized traffic against a queue-based model.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_instr = 32'd0;
   logic [2:0]  in_immsrc = 3'd0;
   logic [4:0]  in_tag = 5'd0;

   logic        rdy_a, vld_a, ill_a;
   logic [31:0] imm_a;
   logic [2:0]  fmt_a;
   logic [4:0]  tag_a;
   logic        rdy_b, vld_b, ill_b;
   logic [63:0] imm_b;
   logic [2:0]  fmt_b;
   logic [4:0]  tag_b;
   logic        rdy_c, vld_c, ill_c;
   logic [31:0] imm_c;
   logic [2:0]  fmt_c;
   logic [4:0]  tag_c;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1), .TAG_W(5)) u_a (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy_a), .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
      .out_valid(vld_a), .out_ready(out_ready), .out_immext(imm_a), .out_fmt(fmt_a),
      .out_illegal(ill_a), .out_tag(tag_a));

   imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1), .TAG_W(5)) u_b (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy_b), .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
      .out_valid(vld_b), .out_ready(out_ready), .out_immext(imm_b), .out_fmt(fmt_b),
      .out_illegal(ill_b), .out_tag(tag_b));

   imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0), .TAG_W(5)) u_c (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy_c), .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
      .out_valid(vld_c), .out_ready(out_ready), .out_immext(imm_c), .out_fmt(fmt_c),
      .out_illegal(ill_c), .out_tag(tag_c));

   typedef struct {
      longint     imm_a, imm_b, imm_c;
      logic [2:0] fmt_a, fmt_b, fmt_c;
      bit         ill_a, ill_b, ill_c;
      logic [4:0] tag;
   } exp_t;

   exp_t q[$];
   bit   exp_rdy = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Immediate value from the field layout of each format, built with signed-int arithmetic.
   function automatic void ref_dec(input logic [31:0] ins, input bit x64, input bit aut,
                                   input logic [2:0] src, output longint imm,
                                   output logic [2:0] fmt, output bit ill);
      int si;
      bit zero;
      bit sh5;
      logic [2:0] f3;
      si   = int'(ins);
      zero = 1'b0;
      sh5  = 1'b0;
      f3   = ins[14:12];
      fmt  = 3'd7;
      if (!aut) begin
         fmt = src;
      end else begin
         case (ins[6:0])
            7'h13: fmt = (f3 == 3'b001 || f3 == 3'b101) ? 3'd0 : 3'd1;
            7'h1B: if (x64) begin
               fmt = (f3 == 3'b001 || f3 == 3'b101) ? 3'd0 : 3'd1;
               sh5 = 1'b1;
            end
            7'h03, 7'h67: fmt = 3'd1;
            7'h23: fmt = 3'd2;
            7'h63: fmt = 3'd3;
            7'h37, 7'h17: fmt = 3'd4;
            7'h6F: fmt = 3'd5;
            7'h73: fmt = ins[14] ? 3'd6 : 3'd1;
            7'h33: begin fmt = 3'd0; zero = 1'b1; end
            default: fmt = 3'd7;
         endcase
      end
      ill = (fmt == 3'd7);
      case (fmt)
         3'd0: imm = (x64 && !sh5) ? longint'((ins >> 20) & 32'h3F) : longint'((ins >> 20) & 32'h1F);
         3'd1: imm = longint'(si >>> 20);
         3'd2: imm = longint'(((si >>> 25) <<< 5) | int'((ins >> 7) & 32'h1F));
         3'd3: imm = longint'(((si >>> 31) <<< 12) | (int'(ins[7]) << 11)
                              | (int'((ins >> 25) & 32'h3F) << 5) | (int'((ins >> 8) & 32'hF) << 1));
         3'd4: imm = longint'(int'(ins & 32'hFFFFF000));
         3'd5: imm = longint'(((si >>> 31) <<< 20) | (int'((ins >> 12) & 32'hFF) << 12)
                              | (int'(ins[20]) << 11) | (int'((ins >> 21) & 32'h3FF) << 1));
         3'd6: imm = longint'((ins >> 15) & 32'h1F);
         default: imm = 0;
      endcase
      if (zero) imm = 0;
      if (!x64) imm = imm & 64'hFFFF_FFFF;
   endfunction

   task automatic check(input string tg, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tg, got, want);
      end
   endtask

   // Called at a negedge with inputs already driven; checks outputs, advances one clock, updates the model.
   task automatic cycle();
      exp_t e;
      bit   push;
      bit   pop;
      check("a.in_ready", 64'(rdy_a), 64'(exp_rdy));
      check("b.in_ready", 64'(rdy_b), 64'(exp_rdy));
      check("c.in_ready", 64'(rdy_c), 64'(exp_rdy));
      check("a.out_valid", 64'(vld_a), 64'(q.size() != 0));
      check("b.out_valid", 64'(vld_b), 64'(q.size() != 0));
      check("c.out_valid", 64'(vld_c), 64'(q.size() != 0));
      if (q.size() != 0) begin
         check("a.immext", 64'(imm_a), q[0].imm_a);
         check("a.fmt", 64'(fmt_a), 64'(q[0].fmt_a));
         check("a.illegal", 64'(ill_a), 64'(q[0].ill_a));
         check("a.tag", 64'(tag_a), 64'(q[0].tag));
         check("b.immext", imm_b, q[0].imm_b);
         check("b.fmt", 64'(fmt_b), 64'(q[0].fmt_b));
         check("b.illegal", 64'(ill_b), 64'(q[0].ill_b));
         check("b.tag", 64'(tag_b), 64'(q[0].tag));
         check("c.immext", 64'(imm_c), q[0].imm_c);
         check("c.fmt", 64'(fmt_c), 64'(q[0].fmt_c));
         check("c.illegal", 64'(ill_c), 64'(q[0].ill_c));
         check("c.tag", 64'(tag_c), 64'(q[0].tag));
      end
      push = in_valid && exp_rdy && !reset && !flush;
      pop  = (q.size() != 0) && out_ready && !reset && !flush;
      ref_dec(in_instr, 1'b0, 1'b1, in_immsrc, e.imm_a, e.fmt_a, e.ill_a);
      ref_dec(in_instr, 1'b1, 1'b1, in_immsrc, e.imm_b, e.fmt_b, e.ill_b);
      ref_dec(in_instr, 1'b0, 1'b0, in_immsrc, e.imm_c, e.fmt_c, e.ill_c);
      e.tag = in_tag;
      @(posedge clk);
      if (reset || flush) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(e);
      end
      exp_rdy = !reset && (q.size() < 2);
      @(negedge clk);
   endtask

   // One instruction through an empty pipe, with hard-coded expected results for the 32- and 64-bit decoders.
   task automatic dir(input string nm, input logic [31:0] ins, input logic [63:0] want_a,
                      input logic [2:0] want_fmt, input bit want_ill, input logic [63:0] want_b);
      in_valid  = 1'b1;
      in_instr  = ins;
      in_immsrc = 3'b111;
      in_tag    = 5'($urandom);
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      check({nm, ".valid"}, 64'(vld_a), 64'd1);
      check({nm, ".imm32"}, 64'(imm_a), want_a);
      check({nm, ".fmt32"}, 64'(fmt_a), 64'(want_fmt));
      check({nm, ".ill32"}, 64'(ill_a), 64'(want_ill));
      check({nm, ".imm64"}, imm_b, want_b);
      check({nm, ".ext_ill"}, 64'(ill_c), 64'd1);
      check({nm, ".ext_imm"}, 64'(imm_c), 64'd0);
      cycle();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [13];
      logic [31:0] v;
      ops = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h7F, 7'h0F};
      v = $urandom;
      if ($urandom_range(0, 7) != 0) v[6:0] = ops[$urandom_range(0, 12)];
      return v;
   endfunction

   initial begin
      @(negedge clk);
      cycle();
      check("rst.in_ready", 64'(rdy_a), 64'd0);
      check("rst.out_valid", 64'(vld_a), 64'd0);
      check("rst.immext", 64'(imm_a), 64'd0);
      check("rst.tag", 64'(tag_a), 64'd0);
      reset = 1'b0;
      cycle();
      check("post_rst.in_ready", 64'(rdy_a), 64'd1);

      dir("addi", 32'hFFF00093, 64'hFFFF_FFFF, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
      dir("beq", 32'hFE000EE3, 64'hFFFF_FFFC, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
      dir("jal", 32'h008000EF, 64'h8, 3'd5, 1'b0, 64'h8);
      dir("lui", 32'h123450B7, 64'h1234_5000, 3'd4, 1'b0, 64'h1234_5000);
      dir("lui_neg", 32'h823450B7, 64'h8234_5000, 3'd4, 1'b0, 64'hFFFF_FFFF_8234_5000);
      dir("csrrwi", 32'h300FD073, 64'h1F, 3'd6, 1'b0, 64'h1F);
      dir("bad_op", 32'h0000007F, 64'h0, 3'd7, 1'b1, 64'h0);
      dir("srai_a", 32'h4011D093, 64'h1, 3'd0, 1'b0, 64'h1);
      dir("srai_b", 32'h4211D093, 64'h1, 3'd0, 1'b0, 64'h21);
      dir("add", 32'h00B50533, 64'h0, 3'd0, 1'b0, 64'h0);
      dir("addiw", 32'hFFF5051B, 64'h0, 3'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      dir("sw", 32'hFE112E23, 64'hFFFF_FFFC, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);

      // Backpressure: two accepts fill the buffer, the third waits until a slot frees.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00100093; in_tag = 5'd1; cycle();
      in_instr  = 32'h00200093; in_tag = 5'd2; cycle();
      check("bp.full_rdy", 64'(rdy_a), 64'd0);
      in_instr  = 32'h00300093; in_tag = 5'd3;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("bp.stall_rdy", 64'(rdy_a), 64'd0);
         check("bp.hold_tag", 64'(tag_a), 64'd1);
         check("bp.hold_imm", 64'(imm_a), 64'd1);
      end
      out_ready = 1'b1;
      cycle();
      check("bp.drain1_tag", 64'(tag_a), 64'd2);
      check("bp.reopen_rdy", 64'(rdy_a), 64'd1);
      cycle();
      check("bp.drain2_tag", 64'(tag_a), 64'd3);
      in_valid = 1'b0;
      cycle();
      check("bp.empty", 64'(vld_a), 64'd0);

      // Streaming at occupancy one.
      in_valid = 1'b1;
      in_instr = rand_instr(); in_tag = 5'($urandom);
      cycle();
      for (int i = 0; i < 10; i++) begin
         in_instr = rand_instr(); in_tag = 5'($urandom);
         cycle();
         check("stream.rdy", 64'(rdy_a), 64'd1);
         check("stream.vld", 64'(vld_a), 64'd1);
      end
      in_valid = 1'b0;
      cycle();

      // Flush a full buffer while a push is offered.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFFF00093;
      cycle(); cycle();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush.vld", 64'(vld_a), 64'd0);
      check("flush.imm", 64'(imm_a), 64'd0);
      check("flush.rdy", 64'(rdy_a), 64'd1);
      cycle();

      // Same with reset, which wins over a simultaneous flush.
      in_valid = 1'b1;
      cycle(); cycle();
      reset = 1'b1;
      flush = 1'b1;
      cycle();
      check("rst2.vld", 64'(vld_b), 64'd0);
      check("rst2.rdy", 64'(rdy_b), 64'd0);
      check("rst2.imm", imm_b, 64'd0);
      check("rst2.fmt", 64'(fmt_b), 64'd0);
      check("rst2.ill", 64'(ill_b), 64'd0);
      check("rst2.tag", 64'(tag_b), 64'd0);
      reset = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      cycle();
      check("rst2.reopen", 64'(rdy_b), 64'd1);

      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         in_instr  = rand_instr();
         in_immsrc = 3'($urandom);
         in_tag    = 5'($urandom);
         cycle();
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
